rice_core_irq_ctrl: RTL and testbench
=====================================

RICE_CORE_IRQ_CTRL -- requirements
Module: rice_core_irq_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, core data width; cause code width is XLEN-1.
REQ-002 SHALL have port i_clk  input  1  core clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  synchronous active-low reset, sampled on the rising edge of i_clk.
REQ-004 SHALL have port i_enable  input  1  core enable; low forces idle.
REQ-005 SHALL have port i_mstatus_mie  input  1  global machine interrupt enable.
REQ-006 SHALL have port i_mie  input  3  per-source enables: [0]=MSIE, [1]=MTIE, [2]=MEIE.
REQ-007 SHALL have port i_irq_software  input  1  machine software interrupt level, synchronous to i_clk.
REQ-008 SHALL have port i_irq_timer  input  1  machine timer interrupt level, synchronous to i_clk.
REQ-009 SHALL have port i_irq_external  input  1  machine external interrupt level, possibly asynchronous.
REQ-010 SHALL have port o_mip  output  3  pending bits, same bit order as i_mie.
REQ-011 SHALL have port o_irq_request  output  1  interrupt trap request to the pipeline.
REQ-012 SHALL have port o_irq_code  output  XLEN-1  cause code of the requested interrupt.
REQ-013 SHALL have port i_irq_ack  input  1  pipeline has taken the interrupt trap this cycle.
REQ-014 SHALL have port i_mret  input  1  pipeline executed MRET this cycle.

Function
REQ-015 SHALL register software and timer levels in one flop stage each; o_mip[0] and o_mip[1] are these flops.
REQ-016 SHALL generate o_mip[2] from the external-input stage defined in Configuration.
REQ-017 SHALL compute qualified = o_mip & i_mie, gated by i_mstatus_mie and i_enable.
REQ-018 SHALL select the winning source by fixed priority: external (code 11), then software (code 3), then timer (code 7).
REQ-019 SHALL implement an FSM with states IDLE, REQUEST and IN_TRAP.
REQ-020 SHALL transition IDLE->REQUEST when any qualified bit is set.
REQ-021 SHALL assert o_irq_request (a register) and latch o_irq_code on that same edge, so request appears one cycle after qualification.
REQ-022 SHALL hold o_irq_request high and o_irq_code frozen while in REQUEST, even if the pending source deasserts.
REQ-023 SHALL transition REQUEST->IN_TRAP on i_irq_ack, deasserting o_irq_request on the same edge.
REQ-024 SHALL ignore i_mret while in IDLE or REQUEST.
REQ-025 SHALL make no new request while in IN_TRAP.
REQ-026 SHALL transition IN_TRAP->IDLE on i_mret.
REQ-027 SHALL allow a new request no earlier than the cycle after returning to IDLE.
REQ-028 SHALL, when i_enable is low, force state IDLE, o_irq_request=0 and o_irq_code=0 on the next edge; pending flops keep sampling.
REQ-029 SHALL, when i_irq_ack and i_mret are high together in REQUEST, take the ack only (go to IN_TRAP).
REQ-030 SHALL never assert o_irq_request while i_mstatus_mie was low at the qualifying edge.

Reset
REQ-031 SHALL, while i_rst_n is low at a clock edge, set state IDLE, o_irq_request=0, o_irq_code=0, o_mip=0 and all synchronizer flops to 0.
REQ-032 SHALL allow reset asserted mid-REQUEST or mid-IN_TRAP to abort the operation with no residual request after release.

Configuration
REQ-033 SHALL, with RICE_CORE_IRQ_SYNC_EN defined, pass i_irq_external through a 2-flop synchronizer (o_mip[2] rises 2 cycles after input).
REQ-034 SHALL, without RICE_CORE_IRQ_SYNC_EN, use a single flop for i_irq_external (1-cycle latency, same as the other sources).

Verification
REQ-035 SHALL cover: MIE=1, i_mie=3'b010, timer high at cycle 0 -> o_mip[1]=1 at cycle 1, o_irq_request=1 with code 7 at cycle 2.
REQ-036 SHALL cover: all three sources high with all enables set -> code 11; after ack+mret with external low -> code 3.
REQ-037 SHALL cover: request pending, timer drops before ack -> request stays high with code 7 until i_irq_ack, then IN_TRAP.
REQ-038 SHALL cover: in IN_TRAP with software high, no request until i_mret; request reasserts 2 cycles after mret.
REQ-039 SHALL cover: i_mstatus_mie=0 with all sources pending -> o_irq_request stays 0; o_mip=3'b111.
REQ-040 SHALL cover: reset or i_enable low during REQUEST -> o_irq_request=0 next edge; external latency is 2 cycles with RICE_CORE_IRQ_SYNC_EN, 1 cycle without.

Source files
------------

// File: rtl/rice_core_irq_ctrl.sv
// Machine-level interrupt controller: samples sources, prioritises, and runs the request/trap handshake.
// Optional macro RICE_CORE_IRQ_SYNC_EN adds a 2-flop synchronizer on the external interrupt input.
module rice_core_irq_ctrl #(
    parameter int unsigned XLEN = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_mstatus_mie,
    input  logic [2:0]        i_mie,
    input  logic              i_irq_software,
    input  logic              i_irq_timer,
    input  logic              i_irq_external,
    output logic [2:0]        o_mip,
    output logic              o_irq_request,
    output logic [XLEN-2:0]   o_irq_code,
    input  logic              i_irq_ack,
    input  logic              i_mret
);

    localparam int unsigned CODE_W = XLEN - 1;

    localparam int unsigned CODE_MSI = 3;
    localparam int unsigned CODE_MTI = 7;
    localparam int unsigned CODE_MEI = 11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQUEST  = 2'd1,
        ST_IN_TRAP  = 2'd2
    } state_e;

    state_e              state_q;
    state_e              state_d;
    logic                sw_q;
    logic                tmr_q;
    logic                ext_pend;
    logic [2:0]          qualified;
    logic                any_qual;
    logic [CODE_W-1:0]   win_code;
    logic                req_q;
    logic                req_d;
    logic [CODE_W-1:0]   code_q;
    logic [CODE_W-1:0]   code_d;

    // Software and timer levels are already synchronous: one stage each.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sw_q  <= 1'b0;
            tmr_q <= 1'b0;
        end else begin
            sw_q  <= i_irq_software;
            tmr_q <= i_irq_timer;
        end
    end

`ifdef RICE_CORE_IRQ_SYNC_EN
    logic ext_meta_q;
    logic ext_sync_q;

    // External line may be asynchronous: two-flop synchronizer.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ext_meta_q <= 1'b0;
            ext_sync_q <= 1'b0;
        end else begin
            ext_meta_q <= i_irq_external;
            ext_sync_q <= ext_meta_q;
        end
    end

    assign ext_pend = ext_sync_q;
`else
    logic ext_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ext_q <= 1'b0;
        end else begin
            ext_q <= i_irq_external;
        end
    end

    assign ext_pend = ext_q;
`endif

    assign o_mip = {ext_pend, tmr_q, sw_q};

    assign qualified = o_mip & i_mie & {3{i_mstatus_mie & i_enable}};
    assign any_qual  = |qualified;

    // Fixed priority: external, then software, then timer.
    always_comb begin
        win_code = '0;
        if (qualified[2]) begin
            win_code = CODE_W'(CODE_MEI);
        end else if (qualified[0]) begin
            win_code = CODE_W'(CODE_MSI);
        end else if (qualified[1]) begin
            win_code = CODE_W'(CODE_MTI);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; ack wins over a simultaneous mret while requesting.
    always_comb begin
        state_d = state_q;
        if (!i_enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_qual) begin
                        state_d = ST_REQUEST;
                    end
                end
                ST_REQUEST: begin
                    if (i_irq_ack) begin
                        state_d = ST_IN_TRAP;
                    end
                end
                ST_IN_TRAP: begin
                    if (i_mret) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output next values; code stays frozen once latched until disabled or reset.
    always_comb begin
        req_d  = req_q;
        code_d = code_q;
        if (!i_enable) begin
            req_d  = 1'b0;
            code_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    req_d = 1'b0;
                    if (any_qual) begin
                        req_d  = 1'b1;
                        code_d = win_code;
                    end
                end
                ST_REQUEST: begin
                    if (i_irq_ack) begin
                        req_d = 1'b0;
                    end
                end
                ST_IN_TRAP: begin
                    req_d = 1'b0;
                end
                default: begin
                    req_d  = 1'b0;
                    code_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            req_q  <= 1'b0;
            code_q <= '0;
        end else begin
            req_q  <= req_d;
            code_q <= code_d;
        end
    end

    assign o_irq_request = req_q;
    assign o_irq_code    = code_q;

endmodule

// File: tb/tb_rice_core_irq_ctrl.sv
// Scoreboard bench for rice_core_irq_ctrl: directed stimulus queues expected request rises,
// a monitor matches them; level checks cover reset, masking, trap blocking and enable/reset aborts.
module tb_rice_core_irq_ctrl;

`ifdef RICE_CORE_IRQ_SYNC_EN
    localparam int EXT_LAT = 2;
`else
    localparam int EXT_LAT = 1;
`endif

    typedef struct {
        int          due;
        logic [30:0] code;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        mstatus_mie;
    logic [2:0]  mie;
    logic        irq_sw;
    logic        irq_tmr;
    logic        irq_ext;
    logic [2:0]  mip;
    logic        irq_req;
    logic [30:0] irq_code;
    logic        irq_ack;
    logic        mret;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    rice_core_irq_ctrl #(.XLEN(32)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_enable       (enable),
        .i_mstatus_mie  (mstatus_mie),
        .i_mie          (mie),
        .i_irq_software (irq_sw),
        .i_irq_timer    (irq_tmr),
        .i_irq_external (irq_ext),
        .o_mip          (mip),
        .o_irq_request  (irq_req),
        .o_irq_code     (irq_code),
        .i_irq_ack      (irq_ack),
        .i_mret         (mret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_req(input int due, input int code);
        exp_t e;
        e.due  = due;
        e.code = 31'(code);
        sb.push_back(e);
    endtask

    // Monitor: every rising o_irq_request must match the oldest expected entry.
    initial begin
        logic prev_req;
        exp_t e;
        prev_req = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (irq_req === 1'b1 && prev_req !== 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_req at cycle %0d: got code %0d expected no request", cyc, irq_code);
                end else begin
                    e = sb.pop_front();
                    if (cyc != e.due || irq_code !== e.code) begin
                        failures++;
                        $display("FAIL req_rise: got cycle %0d code %0d expected cycle %0d code %0d",
                                 cyc, irq_code, e.due, e.code);
                    end
                end
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                e = sb.pop_front();
                checks++;
                failures++;
                $display("FAIL missing_req: got none by cycle %0d expected code %0d at cycle %0d",
                         cyc, e.code, e.due);
            end
            prev_req = irq_req;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] mip_exp;
        rst_n = 1'b0; enable = 1'b1; mstatus_mie = 1'b0; mie = 3'b000;
        irq_sw = 1'b0; irq_tmr = 1'b0; irq_ext = 1'b0; irq_ack = 1'b0; mret = 1'b0;
        step(2);
        irq_sw = 1'b1; irq_tmr = 1'b1; irq_ext = 1'b1;
        step(2);
        chk("reset_req", 32'(irq_req), 0);
        chk("reset_code", 32'(irq_code), 0);
        chk("reset_mip", 32'(mip), 0);
        irq_sw = 1'b0; irq_tmr = 1'b0; irq_ext = 1'b0;
        rst_n = 1'b1;
        step(2);

        // Timer path latency and hold after source drop.
        mstatus_mie = 1'b1; mie = 3'b010; irq_tmr = 1'b1;
        expect_req(cyc + 2, 7);
        step(1);
        chk("tmr_mip_c1", 32'(mip), 32'h2);
        chk("tmr_req_c1", 32'(irq_req), 0);
        step(1);
        chk("tmr_req_c2", 32'(irq_req), 1);
        chk("tmr_code_c2", 32'(irq_code), 7);
        irq_tmr = 1'b0;
        step(2);
        chk("tmr_hold_req", 32'(irq_req), 1);
        chk("tmr_hold_code", 32'(irq_code), 7);
        chk("tmr_drop_mip", 32'(mip), 0);
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        chk("tmr_ack_req", 32'(irq_req), 0);
        mret = 1'b1;
        step(1);
        mret = 1'b0;
        step(3);
        chk("tmr_idle_req", 32'(irq_req), 0);

        // Global disable masks everything; enabling picks external first.
        mstatus_mie = 1'b0; mie = 3'b111;
        irq_sw = 1'b1; irq_tmr = 1'b1; irq_ext = 1'b1;
        step(4);
        chk("mie0_mip", 32'(mip), 32'h7);
        chk("mie0_req", 32'(irq_req), 0);
        mstatus_mie = 1'b1;
        expect_req(cyc + 1, 11);
        step(1);
        chk("all_code", 32'(irq_code), 11);
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        irq_ext = 1'b0;
        step(4);
        chk("trap_blocks_req", 32'(irq_req), 0);
        chk("trap_mip", 32'(mip), 32'h3);
        mret = 1'b1;
        expect_req(cyc + 2, 3);
        step(1);
        mret = 1'b0;
        chk("mret_c1_req", 32'(irq_req), 0);
        step(1);
        chk("sw_code", 32'(irq_code), 3);

        // mret ignored while requesting; ack+mret together takes the ack.
        mret = 1'b1;
        step(1);
        mret = 1'b0;
        chk("mret_in_req_req", 32'(irq_req), 1);
        irq_ack = 1'b1; mret = 1'b1;
        step(1);
        irq_ack = 1'b0; mret = 1'b0;
        step(3);
        chk("ack_mret_trap_req", 32'(irq_req), 0);
        mret = 1'b1;
        expect_req(cyc + 2, 3);
        step(1);
        mret = 1'b0;
        step(1);
        chk("rereq_req", 32'(irq_req), 1);

        // Enable low aborts the request but pending flops keep sampling.
        enable = 1'b0; irq_tmr = 1'b0;
        step(1);
        chk("en_low_req", 32'(irq_req), 0);
        chk("en_low_code", 32'(irq_code), 0);
        step(1);
        chk("en_low_mip", 32'(mip), 32'h1);
        enable = 1'b1;
        expect_req(cyc + 1, 3);
        step(1);
        chk("en_high_req", 32'(irq_req), 1);

        // Reset during REQUEST leaves nothing behind.
        rst_n = 1'b0;
        step(1);
        chk("rst_req_req", 32'(irq_req), 0);
        chk("rst_req_mip", 32'(mip), 0);
        irq_sw = 1'b0;
        rst_n = 1'b1;
        step(4);
        chk("rst_req_after", 32'(irq_req), 0);

        // Reset during IN_TRAP must return to IDLE.
        irq_sw = 1'b1;
        expect_req(cyc + 2, 3);
        step(2);
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        rst_n = 1'b0; irq_sw = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(3);
        chk("rst_trap_req", 32'(irq_req), 0);
        irq_sw = 1'b1;
        expect_req(cyc + 2, 3);
        step(2);
        chk("rst_trap_rereq", 32'(irq_req), 1);
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0; irq_sw = 1'b0;
        step(2);
        mret = 1'b1;
        step(1);
        mret = 1'b0;
        step(2);

        // External input latency.
        mie = 3'b100; irq_ext = 1'b1;
        expect_req(cyc + EXT_LAT + 1, 11);
        step(1);
        mip_exp = (EXT_LAT == 1) ? 3'b100 : 3'b000;
        chk("ext_mip_c1", 32'(mip), 32'(mip_exp));
        step(EXT_LAT);
        chk("ext_req", 32'(irq_req), 1);
        chk("ext_code", 32'(irq_code), 11);
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0; irq_ext = 1'b0;
        step(3);
        mret = 1'b1;
        step(1);
        mret = 1'b0;
        step(5);

        chk("sb_drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
